// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Bundle of the program-loader signals: load control, the
//                source stream handshake, the program-memory write port and
//                the processor release/status outputs.
//                master : the side that drives the stream (load_req,
//                         in_valid, in_data, in_last) and observes the rest.
//                slave  : the loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int OPCODE_W   = 1,
    parameter int REG_ADDR_W = 3,
    parameter int ADDR_W     = 8
);
    localparam int INSTR_W = OPCODE_W + 2*REG_ADDR_W + ADDR_W;

    logic               load_req;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_data;
    logic               in_last;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic               cpu_run;
    logic [ADDR_W:0]    load_count;
    logic               overflow_err;

    modport master (
        output load_req, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_count, overflow_err
    );

    modport slave (
        input  load_req, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_count, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Streams a program into program memory and then releases the
//                processor. Words {opcode, reg1, reg2, branch} arrive on a
//                valid/ready stream; each accepted word is written one cycle
//                later at consecutive addresses. The final word (in_last)
//                moves to RUN and cpu_run rises one cycle after the last
//                write strobe. A program longer than the memory stops at the
//                top address with overflow_err set.
//  Ports       : clk          - clock, rising edge
//                n_reset      - asynchronous active-low reset
//                bus.load_req - pulse: start / restart a load
//                bus.in_*     - source stream (valid/ready/data/last)
//                bus.mem_*    - program-memory write port (1-cycle latency)
//                bus.cpu_run  - processor release
//                bus.load_count / bus.overflow_err - load status
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int OPCODE_W   = 1,
    parameter int REG_ADDR_W = 3,
    parameter int ADDR_W     = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    prog_loader_if.slave bus
);
    localparam int INSTR_W = OPCODE_W + 2*REG_ADDR_W + ADDR_W;
    localparam int DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] C_TOP_ADDR = (ADDR_W+1)'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               run_dly_q;
    logic               cpu_run_q;

    logic w_ready;
    logic w_hs;
    logic w_at_top;

    // A load_req cycle never accepts a word, even when already loading.
    assign w_ready  = (state_q == ST_LOAD) && !bus.load_req;
    assign w_hs     = w_ready && bus.in_valid;
    assign w_at_top = (count_q == C_TOP_ADDR);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.load_req) begin
            state_d = ST_LOAD;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (w_hs) begin
            count_d = count_q + 1'b1;
            if (bus.in_last) begin
                state_d = ST_RUN;
            end else if (w_at_top) begin
                // Memory is full and more words are coming: stop here
                // rather than wrapping onto address 0.
                state_d = ST_ERROR;
                ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            run_dly_q <= 1'b0;
            cpu_run_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            we_q    <= w_hs;
            if (w_hs) begin
                // The write address is the number of words accepted so far.
                addr_q  <= count_q[ADDR_W-1:0];
                wdata_q <= bus.in_data;
            end
            // Two-stage release: RUN is entered at the last handshake, the
            // last strobe occupies the next cycle, and cpu_run follows one
            // cycle later so the memory already holds the final word.
            run_dly_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
            cpu_run_q <= (state_d == ST_RUN) && run_dly_q;
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.cpu_run      = cpu_run_q;
    assign bus.load_count   = count_q;
    assign bus.overflow_err = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Bench for prog_loader. Two loaders share one stimulus
//                stream: A uses the default 256-word memory, B a 4-word
//                memory (ADDR_W=2). An integer-level model of each loader
//                predicts the outputs, which are compared every cycle; a
//                few literal expectations pin the model to known values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_ERR  = 3;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    logic        s_lr   = 1'b0;
    logic        s_v    = 1'b0;
    logic        s_last = 1'b0;
    logic [14:0] s_data = '0;

    prog_loader_if #(.OPCODE_W(1), .REG_ADDR_W(3), .ADDR_W(8)) ifa ();
    prog_loader_if #(.OPCODE_W(1), .REG_ADDR_W(3), .ADDR_W(2)) ifb ();

    assign ifa.load_req = s_lr;
    assign ifa.in_valid = s_v;
    assign ifa.in_last  = s_last;
    assign ifa.in_data  = s_data;
    assign ifb.load_req = s_lr;
    assign ifb.in_valid = s_v;
    assign ifb.in_last  = s_last;
    assign ifb.in_data  = s_data[8:0];

    prog_loader #(.OPCODE_W(1), .REG_ADDR_W(3), .ADDR_W(8)) dut_a (
        .clk(clk), .n_reset(n_reset), .bus(ifa));
    prog_loader #(.OPCODE_W(1), .REG_ADDR_W(3), .ADDR_W(2)) dut_b (
        .clk(clk), .n_reset(n_reset), .bus(ifb));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode [2];
    int          m_cnt  [2];
    int          m_age  [2];   // edges spent in RUN since entering it
    bit          m_we   [2];
    int          m_addr [2];
    logic [14:0] m_data [2];
    bit          m_ovf  [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    function automatic logic [14:0] mask_of(input int i);
        return (i == 0) ? 15'h7FFF : 15'h01FF;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_cnt[i] = 0; m_age[i] = 0;
            m_we[i] = 0; m_addr[i] = 0; m_data[i] = '0; m_ovf[i] = 0;
        end
    endtask

    task automatic m_step();
        bit hs;
        for (int i = 0; i < 2; i++) begin
            hs = (m_mode[i] == M_LOAD) && !s_lr && s_v;
            m_we[i] = hs;
            if (hs) begin
                m_addr[i] = m_cnt[i];
                m_data[i] = s_data & mask_of(i);
            end
            if (s_lr) begin
                m_mode[i] = M_LOAD; m_cnt[i] = 0; m_ovf[i] = 0; m_age[i] = 0;
            end else if (hs) begin
                m_cnt[i]++;
                if (s_last) begin
                    m_mode[i] = M_RUN; m_age[i] = 0;
                end else if (m_cnt[i] == depth_of(i)) begin
                    m_mode[i] = M_ERR; m_ovf[i] = 1;
                end
            end else if (m_mode[i] == M_RUN) begin
                m_age[i]++;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge n_reset);
            if (!n_reset) m_reset();
            else m_step();
        end
    end

    task automatic cmp_one(input int i, input logic rdy, input logic we,
                           input logic [7:0] addr, input logic [14:0] wd,
                           input logic run, input logic [8:0] cnt, input logic ovf);
        string p;
        p = (i == 0) ? "A" : "B";
        chk({p, ".in_ready"}, 32'(rdy), 32'((m_mode[i] == M_LOAD) && !s_lr));
        chk({p, ".mem_we"}, 32'(we), 32'(m_we[i]));
        if (m_we[i]) begin
            chk({p, ".mem_addr"}, 32'(addr), 32'(m_addr[i]));
            chk({p, ".mem_wdata"}, 32'(wd), 32'(m_data[i]));
        end
        chk({p, ".cpu_run"}, 32'(run), 32'((m_mode[i] == M_RUN) && (m_age[i] >= 2)));
        chk({p, ".load_count"}, 32'(cnt), 32'(m_cnt[i]));
        chk({p, ".overflow_err"}, 32'(ovf), 32'(m_ovf[i]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_one(0, ifa.in_ready, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata,
                    ifa.cpu_run, ifa.load_count, ifa.overflow_err);
            cmp_one(1, ifb.in_ready, ifb.mem_we, 8'(ifb.mem_addr), 15'(ifb.mem_wdata),
                    ifb.cpu_run, 9'(ifb.load_count), ifb.overflow_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        s_v = 1'b0; s_last = 1'b0; s_lr = 1'b0; s_data = 15'($urandom);
    endtask

    task automatic start_load();
        idle(); s_lr = 1'b1; step(); s_lr = 1'b0;
    endtask

    task automatic send(input logic [14:0] d, input logic last);
        s_v = 1'b1; s_data = d; s_last = last; step(); idle();
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, ".in_ready"}, 32'(ifa.in_ready), 0);
        chk({tag, ".mem_we"}, 32'(ifa.mem_we), 0);
        chk({tag, ".mem_addr"}, 32'(ifa.mem_addr), 0);
        chk({tag, ".mem_wdata"}, 32'(ifa.mem_wdata), 0);
        chk({tag, ".cpu_run"}, 32'(ifa.cpu_run), 0);
        chk({tag, ".load_count"}, 32'(ifa.load_count), 0);
        chk({tag, ".overflow_err"}, 32'(ifa.overflow_err), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        repeat (3) @(posedge clk);
        #2;
        chk_a_zero("rst");
        chk("rst.B.load_count", 32'(ifb.load_count), 0);
        n_reset = 1'b1;
        step();

        // Basic two-word load.
        start_load();
        send(15'h0009, 1'b0);
        chk("basic.we0", 32'(ifa.mem_we), 1);
        chk("basic.addr0", 32'(ifa.mem_addr), 0);
        chk("basic.data0", 32'(ifa.mem_wdata), 32'h0009);
        send(15'h4A01, 1'b1);
        chk("basic.addr1", 32'(ifa.mem_addr), 1);
        chk("basic.data1", 32'(ifa.mem_wdata), 32'h4A01);
        chk("basic.count", 32'(ifa.load_count), 2);
        chk("basic.run_n0", 32'(ifa.cpu_run), 0);
        step();
        chk("basic.run_n1", 32'(ifa.cpu_run), 0);
        chk("basic.we_off", 32'(ifa.mem_we), 0);
        step();
        chk("basic.run_n2", 32'(ifa.cpu_run), 1);

        // Backpressure and gaps, 5 words, last on the 5th.
        start_load();
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 2)) begin
                s_v = 1'b0; s_last = 1'($urandom); s_data = 15'($urandom);
                step();
            end
            send(15'($urandom), k == 4);
        end
        step(); step();
        chk("gaps.A.run", 32'(ifa.cpu_run), 1);
        chk("gaps.A.count", 32'(ifa.load_count), 5);
        chk("gaps.B.ovf", 32'(ifb.overflow_err), 1);

        // Overflow on B: 5 words, none last.
        start_load();
        for (int k = 0; k < 4; k++) send(15'($urandom), 1'b0);
        chk("ovf.B.we3", 32'(ifb.mem_we), 1);
        chk("ovf.B.addr3", 32'(ifb.mem_addr), 3);
        chk("ovf.B.err", 32'(ifb.overflow_err), 1);
        chk("ovf.B.run", 32'(ifb.cpu_run), 0);
        s_v = 1'b1; s_data = 15'($urandom); s_last = 1'b0;
        #1;
        chk("ovf.B.ready5", 32'(ifb.in_ready), 0);
        step(); idle();
        chk("ovf.B.we5", 32'(ifb.mem_we), 0);
        chk("ovf.B.count", 32'(ifb.load_count), 4);
        chk("ovf.A.count", 32'(ifa.load_count), 5);

        // Exactly full on B: 4 words, last on the 4th.
        start_load();
        for (int k = 0; k < 4; k++) send(15'($urandom), k == 3);
        step(); step();
        chk("full.B.ovf", 32'(ifb.overflow_err), 0);
        chk("full.B.run", 32'(ifb.cpu_run), 1);
        chk("full.B.count", 32'(ifb.load_count), 4);

        // Restart during LOAD after 3 words.
        start_load();
        for (int k = 0; k < 3; k++) send(15'($urandom), 1'b0);
        s_lr = 1'b1; s_v = 1'b1; s_data = 15'h1234;
        #1;
        chk("rst_ld.ready", 32'(ifa.in_ready), 0);
        step(); idle();
        chk("rst_ld.we", 32'(ifa.mem_we), 0);
        chk("rst_ld.count0", 32'(ifa.load_count), 0);
        send(15'h0ABC, 1'b0);
        chk("rst_ld.addr0", 32'(ifa.mem_addr), 0);
        send(15'h7001, 1'b1);
        chk("rst_ld.addr1", 32'(ifa.mem_addr), 1);
        chk("rst_ld.data1", 32'(ifa.mem_wdata), 32'h7001);
        chk("rst_ld.count", 32'(ifa.load_count), 2);
        step(); step();

        // Reset in the middle of a load.
        start_load();
        send(15'($urandom), 1'b0);
        send(15'($urandom), 1'b0);
        s_v = 1'b1; s_data = 15'($urandom); s_last = 1'b0;
        #4;
        n_reset = 1'b0;
        #1;
        chk_a_zero("mid_rst");
        chk("mid_rst.B.we", 32'(ifb.mem_we), 0);
        #11;
        n_reset = 1'b1;
        idle();
        step();
        for (int k = 0; k < 3; k++) begin
            s_v = 1'b1; s_last = 1'($urandom); s_data = 15'($urandom);
            step();
        end
        idle();
        chk("mid_rst.idle_count", 32'(ifa.load_count), 0);
        start_load();
        send(15'h0042, 1'b1);
        step(); step();
        chk("mid_rst.resume_run", 32'(ifa.cpu_run), 1);

        // Randomized loads with random gaps, lengths, lasts and restarts.
        for (int t = 0; t < 20; t++) begin
            start_load();
            repeat ($urandom_range(1, 8)) begin
                s_v    = 1'($urandom_range(0, 3) != 0);
                s_last = 1'($urandom_range(0, 4) == 0);
                s_lr   = 1'($urandom_range(0, 15) == 0);
                s_data = 15'($urandom);
                step();
            end
            idle();
            repeat ($urandom_range(1, 3)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter OPCODE_W, default 1, meaning opcode field width.
REQ-002 SHALL have parameter REG_ADDR_W, default 3, meaning register-address field width.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning program-memory address / branch field width.
REQ-004 SHALL derive INSTR_W = OPCODE_W + 2*REG_ADDR_W + ADDR_W (default 15) and DEPTH = 2**ADDR_W, with instruction packing {opcode, reg1, reg2, branch}, MSB first.
REQ-005 SHALL have the following ports, each listed as name, direction, width, meaning:
- clk, input, 1, sole clock, rising edge.
- n_reset, input, 1, reset, asynchronous, active-low.
- load_req, input, 1, one-cycle pulse that starts or restarts a program load.
- in_valid, input, 1, source word valid.
- in_ready, output, 1, loader accepts word.
- in_data, input, INSTR_W, instruction word.
- in_last, input, 1, final word of program (qualified by in_valid).
- mem_we, output, 1, program-memory write strobe.
- mem_addr, output, ADDR_W, write address.
- mem_wdata, output, INSTR_W, write data.
- cpu_run, output, 1, releases processor (0 holds it in reset).
- load_count, output, ADDR_W+1, words accepted in current load.
- overflow_err, output, 1, program exceeded DEPTH.

Function
REQ-006 SHALL implement states IDLE, LOAD, RUN, ERROR.
REQ-007 SHALL accept a word (handshake) only in a cycle where in_valid=1 and in_ready=1.
REQ-008 SHALL drive in_ready = 1 only in state LOAD and only in cycles where load_req=0.
REQ-009 SHALL transition from IDLE, RUN or ERROR to LOAD on load_req=1, clearing the write address, load_count and overflow_err at that edge.
REQ-010 SHALL treat load_req=1 while in LOAD as a restart: address and load_count return to 0, and no word is accepted in that cycle.
REQ-011 SHALL, for a handshake at edge N, assert mem_we=1 for exactly one cycle after edge N, with mem_addr = current write address and mem_wdata = in_data (1-cycle registered latency).
REQ-012 SHALL keep mem_we=0 in all other cycles, and increment the write address and load_count by 1 per handshake.
REQ-013 SHALL, on a handshake with in_last=1, go to RUN; cpu_run SHALL rise at edge N+2, one cycle after the last write strobe, so that memory is valid.
REQ-014 SHALL, on a handshake at address DEPTH-1 with in_last=0, still write that word, then go to ERROR with overflow_err=1 and cpu_run=0; the address SHALL NOT wrap.
REQ-015 SHALL, on a handshake at address DEPTH-1 with in_last=1, go to RUN with no error (exactly full program).
REQ-016 SHALL hold cpu_run=1 only in RUN, and drop it at the edge leaving RUN (load_req).
REQ-017 SHALL keep load_count stable outside LOAD; its maximum value is DEPTH.
REQ-018 SHALL ignore in_valid and in_last outside LOAD; in_last without in_valid has no effect.

Reset
REQ-019 SHALL, on n_reset=0 (asynchronous, any cycle including mid-load), force state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_count=0, overflow_err=0.
REQ-020 SHALL NOT issue a write strobe for a handshake whose registered write would fall after reset assertion; loading resumes only after a new load_req.

Verification
REQ-021 Bench SHALL check a basic load: after reset release, load_req, then words 15'h0009 and 15'h4A01 (last) -> writes to address 0 then 1, load_count=2, cpu_run=1 two cycles after the second handshake.
REQ-022 Bench SHALL check backpressure and gaps: in_valid toggled randomly over 5 words (last on the 5th) -> exactly 5 strobes at addresses 0..4 in order with matching data, and no strobe in idle cycles.
REQ-023 Bench SHALL check overflow with ADDR_W=2: 5 words, none last -> 4 writes at addresses 0..3, overflow_err=1 after the 4th, cpu_run=0, 5th word never accepted (in_ready=0).
REQ-024 Bench SHALL check exact full with ADDR_W=2: 4 words, last on the 4th -> overflow_err=0, cpu_run=1, load_count=4.
REQ-025 Bench SHALL check restart: load_req in LOAD after 3 words, then 2 words (last) -> writes at addresses 0,1 follow, load_count=2, and no handshake occurs in the load_req cycle.
REQ-026 Bench SHALL check reset mid-load: n_reset low for 12 ns during LOAD -> all outputs at reset values immediately (asynchronously), and the state stays IDLE until load_req.
